// File: rtl/fetch_seq_unit_if.sv
// Control/status bundle between the decoder, the fetch sequencer and the ROM address port.
// The decoder side is the master; the sequencer itself uses the slave modport.
interface fetch_seq_unit_if #(
  parameter int PC_W      = 8,
  parameter int CNT_W     = 16,
  parameter int RAS_DEPTH = 4
);
  localparam int RD_W = $clog2(RAS_DEPTH) + 1;

  logic            Start;
  logic [PC_W-1:0] Start_Addr;
  logic            Halt;
  logic            Branch;
  logic            BranchCond;
  logic [PC_W-1:0] Offset;
  logic            Call;
  logic            Ret;

  logic [PC_W-1:0]  PC;
  logic             Running;
  logic             Halted;
  logic [CNT_W-1:0] InstrCount;
  logic [RD_W-1:0]  RasDepth;
  logic             StackOvf;
  logic             StackUnf;

  modport master (
    output Start, Start_Addr, Halt, Branch, BranchCond, Offset, Call, Ret,
    input  PC, Running, Halted, InstrCount, RasDepth, StackOvf, StackUnf
  );

  modport slave (
    input  Start, Start_Addr, Halt, Branch, BranchCond, Offset, Call, Ret,
    output PC, Running, Halted, InstrCount, RasDepth, StackOvf, StackUnf
  );
endinterface

// File: rtl/fetch_seq_unit.sv
// Instruction fetch sequencer: owns the PC, IDLE/RUN/HALT sequencing, a hardware
// return-address stack with sticky over/underflow flags, and a saturating retire counter.
module fetch_seq_unit #(
  parameter int PC_W      = 8,
  parameter int CNT_W     = 16,
  parameter int RAS_DEPTH = 4
) (
  input logic             CLK,
  input logic             RST_n,
  fetch_seq_unit_if.slave bus
);
  localparam int RD_W  = $clog2(RAS_DEPTH) + 1;
  localparam int IDX_W = $clog2(RAS_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t           state;
  logic             armed;
  logic [PC_W-1:0]  pc;
  logic [CNT_W-1:0] instrCount;
  logic [RD_W-1:0]  rasDepth;
  logic             stackOvf;
  logic             stackUnf;
  logic             running;
  logic             halted;
  logic [PC_W-1:0]  ras [RAS_DEPTH];

  logic             isFull;
  logic             isEmpty;
  logic [IDX_W-1:0] pushIdx;
  logic [IDX_W-1:0] topIdx;
  logic [PC_W-1:0]  pcPlus1;
  logic [PC_W-1:0]  pcBranch;
  logic             pushEn;

  // Offset is already PC_W wide, so a plain modulo add is the sign-extended displacement.
  assign isFull   = (rasDepth == RD_W'(RAS_DEPTH));
  assign isEmpty  = (rasDepth == '0);
  assign pushIdx  = rasDepth[IDX_W-1:0];
  assign topIdx   = pushIdx - IDX_W'(1);
  assign pcPlus1  = pc + PC_W'(1);
  assign pcBranch = pc + bus.Offset;
  assign pushEn   = (state == RUN) && !bus.Start && !bus.Halt && !bus.Ret && bus.Call && !isFull;

  // Stack storage needs no reset: entries at or above rasDepth are never read.
  always_ff @(posedge CLK) begin
    if (pushEn) begin
      ras[pushIdx] <= pcPlus1;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state      <= IDLE;
      armed      <= 1'b0;
      pc         <= '0;
      instrCount <= '0;
      rasDepth   <= '0;
      stackOvf   <= 1'b0;
      stackUnf   <= 1'b0;
      running    <= 1'b0;
      halted     <= 1'b0;
    end else if (bus.Start) begin
      state      <= IDLE;
      armed      <= 1'b1;
      pc         <= bus.Start_Addr;
      instrCount <= '0;
      rasDepth   <= '0;
      stackOvf   <= 1'b0;
      stackUnf   <= 1'b0;
      running    <= 1'b0;
      halted     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (armed) begin
            state   <= RUN;
            running <= 1'b1;
            armed   <= 1'b0;
          end
        end
        RUN: begin
          if (bus.Halt) begin
            state   <= HALT;
            running <= 1'b0;
            halted  <= 1'b1;
          end else begin
            if (instrCount != '1) begin
              instrCount <= instrCount + CNT_W'(1);
            end
            // Ret beats Call beats a taken Branch; anything else falls through sequentially.
            if (bus.Ret) begin
              if (!isEmpty) begin
                pc       <= ras[topIdx];
                rasDepth <= rasDepth - RD_W'(1);
              end else begin
                stackUnf <= 1'b1;
                pc       <= pcPlus1;
              end
            end else if (bus.Call) begin
              pc <= pcBranch;
              if (isFull) begin
                stackOvf <= 1'b1;
              end else begin
                rasDepth <= rasDepth + RD_W'(1);
              end
            end else if (bus.Branch && bus.BranchCond) begin
              pc <= pcBranch;
            end else begin
              pc <= pcPlus1;
            end
          end
        end
        HALT: begin
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
          halted  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.PC         = pc;
  assign bus.Running    = running;
  assign bus.Halted     = halted;
  assign bus.InstrCount = instrCount;
  assign bus.RasDepth   = rasDepth;
  assign bus.StackOvf   = stackOvf;
  assign bus.StackUnf   = stackUnf;
endmodule

// File: tb/tb_fetch_seq_unit.sv
// Scenario bench for fetch_seq_unit: expected snapshots are queued as stimulus is driven
// and popped once the following edge has been taken. A CNT_W=4 copy shadows the main DUT.
module tb_fetch_seq_unit;
  logic CLK = 1'b0;
  logic RST_n = 1'b1;

  always #5 CLK = ~CLK;

  fetch_seq_unit_if #(.PC_W(8), .CNT_W(16), .RAS_DEPTH(4)) bus ();
  fetch_seq_unit_if #(.PC_W(8), .CNT_W(4),  .RAS_DEPTH(4)) bus4 ();

  fetch_seq_unit #(.PC_W(8), .CNT_W(16), .RAS_DEPTH(4)) dut  (.CLK(CLK), .RST_n(RST_n), .bus(bus));
  fetch_seq_unit #(.PC_W(8), .CNT_W(4),  .RAS_DEPTH(4)) dut4 (.CLK(CLK), .RST_n(RST_n), .bus(bus4));

  assign bus4.Start      = bus.Start;
  assign bus4.Start_Addr = bus.Start_Addr;
  assign bus4.Halt       = bus.Halt;
  assign bus4.Branch     = bus.Branch;
  assign bus4.BranchCond = bus.BranchCond;
  assign bus4.Offset     = bus.Offset;
  assign bus4.Call       = bus.Call;
  assign bus4.Ret        = bus.Ret;

  typedef struct packed {
    logic [7:0]  pc;
    logic        running;
    logic        halted;
    logic [15:0] cnt;
    logic [2:0]  depth;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t       expQ [$];
  logic [3:0] cnt4Q [$];
  int checks = 0;
  int errors = 0;

  function automatic exp_t mk(input logic [7:0] pc, input logic r, input logic h,
                              input logic [15:0] c, input logic [2:0] d,
                              input logic o, input logic u);
    return '{pc, r, h, c, d, o, u};
  endfunction

  function automatic exp_t snap();
    return '{bus.PC, bus.Running, bus.Halted, bus.InstrCount, bus.RasDepth, bus.StackOvf, bus.StackUnf};
  endfunction

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic clearCtl();
    bus.Halt = 1'b0; bus.Branch = 1'b0; bus.BranchCond = 1'b0;
    bus.Offset = 8'h00; bus.Call = 1'b0; bus.Ret = 1'b0;
  endtask

  // Start held two cycles, then released; returns with the unit in RUN at PC=a.
  task automatic applyStimulus(input logic [7:0] a);
    clearCtl();
    bus.Start = 1'b1; bus.Start_Addr = a;
    cycle(); cycle();
    bus.Start = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    exp_t e, a;
    clearCtl(); bus.Start = 1'b0; bus.Start_Addr = 8'h10;
    #1 RST_n = 1'b0;
    #1;
    expQ.push_back(mk(8'h00, 0, 0, 16'd0, 3'd0, 0, 0));
    e = expQ.pop_front(); a = snap(); checks++;
    if (a !== e) begin errors++; $display("[TB] FAIL reset_state actual=%h required=%h", a, e); end
    @(negedge CLK); RST_n = 1'b1;
    expQ.push_back(mk(8'h00, 0, 0, 16'd0, 3'd0, 0, 0));
    cycle();
    e = expQ.pop_front(); a = snap(); checks++;
    if (a !== e) begin errors++; $display("[TB] FAIL reset_unarmed_idle actual=%h required=%h", a, e); end
  endtask

  task automatic test_sequential();
    exp_t e, a;
    clearCtl();
    bus.Start = 1'b1; bus.Start_Addr = 8'h10;
    for (int i = 0; i < 2; i++) begin
      expQ.push_back(mk(8'h10, 0, 0, 16'd0, 3'd0, 0, 0));
      cycle();
      e = expQ.pop_front(); a = snap(); checks++;
      if (a !== e) begin errors++; $display("[TB] FAIL start_hold%0d actual=%h required=%h", i, a, e); end
    end
    bus.Start = 1'b0;
    expQ.push_back(mk(8'h10, 1, 0, 16'd0, 3'd0, 0, 0));
    cycle();
    e = expQ.pop_front(); a = snap(); checks++;
    if (a !== e) begin errors++; $display("[TB] FAIL start_run actual=%h required=%h", a, e); end
    for (int i = 1; i <= 3; i++) begin
      expQ.push_back(mk(8'(8'h10 + i), 1, 0, 16'(i), 3'd0, 0, 0));
      cycle();
      e = expQ.pop_front(); a = snap(); checks++;
      if (a !== e) begin errors++; $display("[TB] FAIL seq_step%0d actual=%h required=%h", i, a, e); end
    end
  endtask

  task automatic test_branch();
    exp_t e, a;
    applyStimulus(8'h20);
    bus.Branch = 1'b1; bus.BranchCond = 1'b1; bus.Offset = 8'hFC;
    expQ.push_back(mk(8'h1C, 1, 0, 16'd1, 3'd0, 0, 0));
    cycle();
    e = expQ.pop_front(); a = snap(); checks++;
    if (a !== e) begin errors++; $display("[TB] FAIL branch_taken actual=%h required=%h", a, e); end
    applyStimulus(8'h20);
    bus.Branch = 1'b1; bus.BranchCond = 1'b0; bus.Offset = 8'hFC;
    expQ.push_back(mk(8'h21, 1, 0, 16'd1, 3'd0, 0, 0));
    cycle();
    e = expQ.pop_front(); a = snap(); checks++;
    if (a !== e) begin errors++; $display("[TB] FAIL branch_not_taken actual=%h required=%h", a, e); end
  endtask

  task automatic test_call_ret();
    exp_t e, a;
    applyStimulus(8'h30);
    bus.Call = 1'b1; bus.Offset = 8'h10;
    expQ.push_back(mk(8'h40, 1, 0, 16'd1, 3'd1, 0, 0));
    cycle();
    e = expQ.pop_front(); a = snap(); checks++;
    if (a !== e) begin errors++; $display("[TB] FAIL call_push actual=%h required=%h", a, e); end
    // A taken branch alongside Ret must lose to the Ret.
    bus.Call = 1'b0; bus.Ret = 1'b1; bus.Branch = 1'b1; bus.BranchCond = 1'b1;
    expQ.push_back(mk(8'h31, 1, 0, 16'd2, 3'd0, 0, 0));
    cycle();
    e = expQ.pop_front(); a = snap(); checks++;
    if (a !== e) begin errors++; $display("[TB] FAIL ret_pop actual=%h required=%h", a, e); end
  endtask

  task automatic test_ras_overflow();
    exp_t e, a;
    logic [7:0] pcExp;
    applyStimulus(8'h50);
    bus.Call = 1'b1; bus.Offset = 8'h10;
    for (int i = 0; i < 5; i++) begin
      pcExp = 8'h50 + 8'(8'h10 * (i + 1));
      expQ.push_back(mk(pcExp, 1, 0, 16'(i + 1), (i < 4) ? 3'(i + 1) : 3'd4, (i == 4), 0));
      cycle();
      e = expQ.pop_front(); a = snap(); checks++;
      if (a !== e) begin errors++; $display("[TB] FAIL call_nest%0d actual=%h required=%h", i, a, e); end
    end
    bus.Call = 1'b0; bus.Ret = 1'b1;
    for (int j = 0; j < 4; j++) begin
      pcExp = 8'h81 - 8'(8'h10 * j);
      expQ.push_back(mk(pcExp, 1, 0, 16'(6 + j), 3'(3 - j), 1, 0));
      cycle();
      e = expQ.pop_front(); a = snap(); checks++;
      if (a !== e) begin errors++; $display("[TB] FAIL ret_unwind%0d actual=%h required=%h", j, a, e); end
    end
    expQ.push_back(mk(8'h52, 1, 0, 16'd10, 3'd0, 1, 1));
    cycle();
    e = expQ.pop_front(); a = snap(); checks++;
    if (a !== e) begin errors++; $display("[TB] FAIL ret_underflow actual=%h required=%h", a, e); end
  endtask

  task automatic test_halt();
    exp_t e, a;
    applyStimulus(8'h08);
    bus.Ret = 1'b1;
    expQ.push_back(mk(8'h09, 1, 0, 16'd1, 3'd0, 0, 1));
    cycle();
    e = expQ.pop_front(); a = snap(); checks++;
    if (a !== e) begin errors++; $display("[TB] FAIL halt_pre_unf actual=%h required=%h", a, e); end
    bus.Ret = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      expQ.push_back(mk(8'(8'h09 + i), 1, 0, 16'(1 + i), 3'd0, 0, 1));
      cycle();
    end
    for (int i = 1; i <= 6; i++) begin
      e = expQ.pop_front();
    end
    a = snap(); checks++;
    if (a !== e) begin errors++; $display("[TB] FAIL halt_pre_count actual=%h required=%h", a, e); end
    bus.Halt = 1'b1; bus.Call = 1'b1; bus.Offset = 8'h10;
    expQ.push_back(mk(8'h0F, 0, 1, 16'd7, 3'd0, 0, 1));
    cycle();
    e = expQ.pop_front(); a = snap(); checks++;
    if (a !== e) begin errors++; $display("[TB] FAIL halt_enter actual=%h required=%h", a, e); end
    bus.Halt = 1'b0; bus.Ret = 1'b1; bus.Branch = 1'b1; bus.BranchCond = 1'b1;
    for (int i = 0; i < 10; i++) begin
      expQ.push_back(mk(8'h0F, 0, 1, 16'd7, 3'd0, 0, 1));
      cycle();
      e = expQ.pop_front(); a = snap(); checks++;
      if (a !== e) begin errors++; $display("[TB] FAIL halt_frozen%0d actual=%h required=%h", i, a, e); end
    end
    clearCtl();
    bus.Start = 1'b1; bus.Start_Addr = 8'h44;
    expQ.push_back(mk(8'h44, 0, 0, 16'd0, 3'd0, 0, 0));
    cycle();
    e = expQ.pop_front(); a = snap(); checks++;
    if (a !== e) begin errors++; $display("[TB] FAIL restart_idle actual=%h required=%h", a, e); end
    bus.Start = 1'b0;
    expQ.push_back(mk(8'h44, 1, 0, 16'd0, 3'd0, 0, 0));
    cycle();
    e = expQ.pop_front(); a = snap(); checks++;
    if (a !== e) begin errors++; $display("[TB] FAIL restart_run actual=%h required=%h", a, e); end
  endtask

  task automatic test_pc_wrap();
    exp_t e, a;
    applyStimulus(8'hFE);
    expQ.push_back(mk(8'hFF, 1, 0, 16'd1, 3'd0, 0, 0));
    expQ.push_back(mk(8'h00, 1, 0, 16'd2, 3'd0, 0, 0));
    cycle();
    e = expQ.pop_front(); a = snap(); checks++;
    if (a !== e) begin errors++; $display("[TB] FAIL pc_to_ff actual=%h required=%h", a, e); end
    cycle();
    e = expQ.pop_front(); a = snap(); checks++;
    if (a !== e) begin errors++; $display("[TB] FAIL pc_wrap actual=%h required=%h", a, e); end
    bus.Branch = 1'b1; bus.BranchCond = 1'b1; bus.Offset = 8'hFC;
    expQ.push_back(mk(8'hFC, 1, 0, 16'd3, 3'd0, 0, 0));
    cycle();
    e = expQ.pop_front(); a = snap(); checks++;
    if (a !== e) begin errors++; $display("[TB] FAIL neg_offset_wrap actual=%h required=%h", a, e); end
    applyStimulus(8'hFF);
    bus.Call = 1'b1; bus.Offset = 8'h02;
    expQ.push_back(mk(8'h01, 1, 0, 16'd1, 3'd1, 0, 0));
    cycle();
    e = expQ.pop_front(); a = snap(); checks++;
    if (a !== e) begin errors++; $display("[TB] FAIL call_at_ff actual=%h required=%h", a, e); end
    bus.Call = 1'b0; bus.Ret = 1'b1;
    expQ.push_back(mk(8'h00, 1, 0, 16'd2, 3'd0, 0, 0));
    cycle();
    e = expQ.pop_front(); a = snap(); checks++;
    if (a !== e) begin errors++; $display("[TB] FAIL ret_addr_wrap actual=%h required=%h", a, e); end
  endtask

  task automatic test_saturation();
    exp_t e, a;
    logic [3:0] c4;
    applyStimulus(8'h00);
    for (int i = 1; i <= 20; i++) begin
      cnt4Q.push_back((i < 15) ? 4'(i) : 4'd15);
      expQ.push_back(mk(8'(i), 1, 0, 16'(i), 3'd0, 0, 0));
      cycle();
      c4 = cnt4Q.pop_front(); checks++;
      if (bus4.InstrCount !== c4) begin
        errors++; $display("[TB] FAIL sat_count4_%0d actual=%0d required=%0d", i, bus4.InstrCount, c4);
      end
      e = expQ.pop_front(); a = snap(); checks++;
      if (a !== e) begin errors++; $display("[TB] FAIL count16_%0d actual=%h required=%h", i, a, e); end
    end
  endtask

  task automatic test_async_reset();
    exp_t e, a;
    applyStimulus(8'h70);
    bus.Call = 1'b1; bus.Offset = 8'h10;
    expQ.push_back(mk(8'h80, 1, 0, 16'd1, 3'd1, 0, 0));
    cycle();
    e = expQ.pop_front(); a = snap(); checks++;
    if (a !== e) begin errors++; $display("[TB] FAIL pre_reset_run actual=%h required=%h", a, e); end
    clearCtl();
    #2 RST_n = 1'b0;
    #1;
    expQ.push_back(mk(8'h00, 0, 0, 16'd0, 3'd0, 0, 0));
    e = expQ.pop_front(); a = snap(); checks++;
    if (a !== e) begin errors++; $display("[TB] FAIL async_reset actual=%h required=%h", a, e); end
    #2 RST_n = 1'b1;
    expQ.push_back(mk(8'h00, 0, 0, 16'd0, 3'd0, 0, 0));
    cycle();
    e = expQ.pop_front(); a = snap(); checks++;
    if (a !== e) begin errors++; $display("[TB] FAIL post_reset_idle actual=%h required=%h", a, e); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] fetch_seq_unit bench starting");
    test_reset();
    test_sequential();
    test_branch();
    test_call_ret();
    test_ras_overflow();
    test_halt();
    test_pc_wrap();
    test_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
